mem_wb_hilo: RTL and testbench

- Receiving end of the MEM-stage writeback interface.
- Registers the MEM-stage writeback bundle (GPR write address, enable and data; HI/LO data and enable) into the MEM/WB pipeline register.
- Drives the GPR write port of the register file and holds the architectural HI and LO registers.
- Supplies current HI/LO values to the EX stage for MFHI/MFLO.

---
 rtl/mem_wb_hilo_pkg.sv | 14 +
 rtl/mem_wb_hilo_if.sv | 31 +++
 rtl/mem_wb_hilo_hilo_reg.sv | 41 ++++
 rtl/mem_wb_hilo.sv | 108 ++++++++++
 tb/tb_mem_wb_hilo.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_hilo_pkg.sv
// Shared pipeline defines for the MEM/WB stage: reset level, write-enable levels, bus widths.
package mem_wb_hilo_pkg;

  localparam logic RESETABLE   = 1'b0;
  localparam logic WRITEABLE   = 1'b1;
  localparam logic UNWRITEABLE = 1'b0;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;

  localparam logic [RegBus-1:0]     ZEROWORD   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

endpackage

// File: rtl/mem_wb_hilo_if.sv
// MEM-to-WB writeback bundle, stall/flush controls and the WB-side results (regfile port, HI/LO).
interface mem_wb_hilo_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              stall_mem;
  logic              stall_wb;
  logic              flush;
  logic [ADDR_W-1:0] mem_wd;
  logic              mem_wreg;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_hi;
  logic [DATA_W-1:0] mem_lo;
  logic              mem_enhilo;
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [31:0]       retired;

  modport master (
    output stall_mem, stall_wb, flush, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_enhilo,
    input  wb_wd, wb_wreg, wb_wdata, hi_o, lo_o, retired
  );

  modport slave (
    input  stall_mem, stall_wb, flush, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_enhilo,
    output wb_wd, wb_wreg, wb_wdata, hi_o, lo_o, retired
  );
endinterface

// File: rtl/mem_wb_hilo_hilo_reg.sv
// Architectural HI/LO register pair; both halves always written together.
module mem_wb_hilo_hilo_reg
  import mem_wb_hilo_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we_i == WRITEABLE) begin
      hi_d = hi_i;
      lo_d = lo_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni == RESETABLE) begin
      hi_q <= DATA_W'(ZEROWORD);
      lo_q <= DATA_W'(ZEROWORD);
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register, GPR write port, HI/LO owner and retire counter.
// Optional HI/LO forwarding to EX is enabled by defining HILO_BYPASS_EN.
module mem_wb_hilo
  import mem_wb_hilo_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus
) (
  input logic          clk,
  input logic          rst,
  mem_wb_hilo_if.slave bus
);

  logic [ADDR_W-1:0] wb_wd_q, wb_wd_d;
  logic              wb_wreg_q, wb_wreg_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
  logic [DATA_W-1:0] wb_hi_q, wb_hi_d;
  logic [DATA_W-1:0] wb_lo_q, wb_lo_d;
  logic              wb_enhilo_q, wb_enhilo_d;
  logic [31:0]       retired_q, retired_d;
  logic              wb_retire;
  logic              hilo_we;
  logic [DATA_W-1:0] arch_hi, arch_lo;

  always_comb begin
    wb_wd_d     = wb_wd_q;
    wb_wreg_d   = wb_wreg_q;
    wb_wdata_d  = wb_wdata_q;
    wb_hi_d     = wb_hi_q;
    wb_lo_d     = wb_lo_q;
    wb_enhilo_d = wb_enhilo_q;
    if (bus.flush || (bus.stall_mem && !bus.stall_wb)) begin
      wb_wd_d     = ADDR_W'(NOPRegAddr);
      wb_wreg_d   = UNWRITEABLE;
      wb_wdata_d  = DATA_W'(ZEROWORD);
      wb_hi_d     = DATA_W'(ZEROWORD);
      wb_lo_d     = DATA_W'(ZEROWORD);
      wb_enhilo_d = UNWRITEABLE;
    end else if (!bus.stall_mem) begin
      wb_wd_d     = bus.mem_wd;
      wb_wreg_d   = bus.mem_wreg;
      wb_wdata_d  = bus.mem_wdata;
      wb_hi_d     = bus.mem_hi;
      wb_lo_d     = bus.mem_lo;
      wb_enhilo_d = bus.mem_enhilo;
    end
  end

  // A held bundle retires and writes HI/LO only on the edge where stall_wb drops.
  assign wb_retire = !bus.stall_wb && (wb_wreg_q || wb_enhilo_q);
  assign retired_d = retired_q + 32'(wb_retire);
  assign hilo_we   = !bus.stall_wb && (wb_enhilo_q == WRITEABLE);

  always_ff @(posedge clk) begin
    if (rst == RESETABLE) begin
      wb_wd_q     <= ADDR_W'(NOPRegAddr);
      wb_wreg_q   <= UNWRITEABLE;
      wb_wdata_q  <= DATA_W'(ZEROWORD);
      wb_hi_q     <= DATA_W'(ZEROWORD);
      wb_lo_q     <= DATA_W'(ZEROWORD);
      wb_enhilo_q <= UNWRITEABLE;
      retired_q   <= '0;
    end else begin
      wb_wd_q     <= wb_wd_d;
      wb_wreg_q   <= wb_wreg_d;
      wb_wdata_q  <= wb_wdata_d;
      wb_hi_q     <= wb_hi_d;
      wb_lo_q     <= wb_lo_d;
      wb_enhilo_q <= wb_enhilo_d;
      retired_q   <= retired_d;
    end
  end

  mem_wb_hilo_hilo_reg #(
    .DATA_W(DATA_W)
  ) u_hilo_reg (
    .clk_i (clk),
    .rst_ni(rst),
    .we_i  (hilo_we),
    .hi_i  (wb_hi_q),
    .lo_i  (wb_lo_q),
    .hi_o  (arch_hi),
    .lo_o  (arch_lo)
  );

  assign bus.wb_wd    = wb_wd_q;
  assign bus.wb_wdata = wb_wdata_q;
  assign bus.wb_wreg  = bus.stall_wb ? UNWRITEABLE : wb_wreg_q;
  assign bus.retired  = retired_q;

`ifdef HILO_BYPASS_EN
  always_comb begin
    bus.hi_o = arch_hi;
    bus.lo_o = arch_lo;
    if (bus.mem_enhilo) begin
      bus.hi_o = bus.mem_hi;
      bus.lo_o = bus.mem_lo;
    end else if (wb_enhilo_q) begin
      bus.hi_o = wb_hi_q;
      bus.lo_o = wb_lo_q;
    end
  end
`else
  assign bus.hi_o = arch_hi;
  assign bus.lo_o = arch_lo;
`endif

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Directed bench for mem_wb_hilo: reset, capture, HI/LO write, stalls, flush, bypass, wrap.
module tb_mem_wb_hilo;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_wb_hilo_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  mem_wb_hilo dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic enhilo, input logic [31:0] hi, input logic [31:0] lo);
    bus.mem_wd     = wd;
    bus.mem_wreg   = wreg;
    bus.mem_wdata  = wdata;
    bus.mem_enhilo = enhilo;
    bus.mem_hi     = hi;
    bus.mem_lo     = lo;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

`ifdef HILO_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b0;
    bus.stall_mem = 1'b0;
    bus.stall_wb  = 1'b0;
    bus.flush     = 1'b0;
    drive(5'd7, 1'b1, 32'hDEAD_0001, 1'b0, 32'h1, 32'h2);
    tick();
    tick();
    check_eq("rst_wd", 32'(bus.wb_wd), 32'h0);
    check_eq("rst_wreg", 32'(bus.wb_wreg), 32'h0);
    check_eq("rst_wdata", bus.wb_wdata, 32'h0);
    check_eq("rst_hi", bus.hi_o, 32'h0);
    check_eq("rst_lo", bus.lo_o, 32'h0);
    check_eq("rst_retired", bus.retired, 32'h0);

    // First capture after reset: one-cycle latency, retire one cycle later.
    rst = 1'b1;
    drive(5'd3, 1'b1, 32'h0000_1234, 1'b0, 32'h0, 32'h0);
    tick();
    check_eq("cap_wd", 32'(bus.wb_wd), 32'd3);
    check_eq("cap_wreg", 32'(bus.wb_wreg), 32'd1);
    check_eq("cap_wdata", bus.wb_wdata, 32'h0000_1234);
    check_eq("cap_ret0", bus.retired, 32'd0);
    idle();
    tick();
    check_eq("cap_ret1", bus.retired, 32'd1);
    check_eq("cap_idle_wreg", 32'(bus.wb_wreg), 32'd0);

    // HI/LO write through MEM -> WB -> architectural.
    drive(5'd0, 1'b0, 32'h0, 1'b1, 32'hAAAA_0000, 32'h0000_BBBB);
    #1;
    check_eq("hl_mem_hi", bus.hi_o, Byp ? 32'hAAAA_0000 : 32'h0);
    tick();
    idle();
    #1;
    check_eq("hl_wb_hi", bus.hi_o, Byp ? 32'hAAAA_0000 : 32'h0);
    check_eq("hl_wb_lo", bus.lo_o, Byp ? 32'h0000_BBBB : 32'h0);
    tick();
    check_eq("hl_arch_hi", bus.hi_o, 32'hAAAA_0000);
    check_eq("hl_arch_lo", bus.lo_o, 32'h0000_BBBB);
    check_eq("hl_ret", bus.retired, 32'd2);

    // stall_mem only: WB gets a bubble.
    drive(5'd5, 1'b1, 32'h55, 1'b1, 32'h1111, 32'h2222);
    bus.stall_mem = 1'b1;
    tick();
    check_eq("smem_wreg", 32'(bus.wb_wreg), 32'd0);
    check_eq("smem_wd", 32'(bus.wb_wd), 32'd0);
    check_eq("smem_ret", bus.retired, 32'd2);
    bus.stall_mem = 1'b0;
    tick();
    check_eq("cap5_wd", 32'(bus.wb_wd), 32'd5);
    check_eq("cap5_wreg", 32'(bus.wb_wreg), 32'd1);

    // Both stalls: bundle held, no writes, until release.
    bus.stall_mem = 1'b1;
    bus.stall_wb  = 1'b1;
    drive(5'd9, 1'b1, 32'h99, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_wreg", 32'(bus.wb_wreg), 32'd0);
      check_eq("hold_ret", bus.retired, 32'd2);
      check_eq("hold_hi", bus.hi_o, Byp ? 32'h1111 : 32'hAAAA_0000);
    end
    check_eq("hold_wd", 32'(bus.wb_wd), 32'd5);
    check_eq("hold_wdata", bus.wb_wdata, 32'h55);
    bus.stall_mem = 1'b0;
    bus.stall_wb  = 1'b0;
    idle();
    #1;
    check_eq("rel_wreg", 32'(bus.wb_wreg), 32'd1);
    tick();
    check_eq("rel_ret", bus.retired, 32'd3);
    check_eq("rel_hi", bus.hi_o, 32'h1111);
    check_eq("rel_lo", bus.lo_o, 32'h2222);
    tick();
    check_eq("rel_once", bus.retired, 32'd3);

    // Flush kills a valid write.
    drive(5'd4, 1'b1, 32'h44, 1'b1, 32'hDEAD, 32'hBEEF);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    #1;
    check_eq("fl_wreg", 32'(bus.wb_wreg), 32'd0);
    check_eq("fl_wd", 32'(bus.wb_wd), 32'd0);
    tick();
    check_eq("fl_hi", bus.hi_o, 32'h1111);
    check_eq("fl_lo", bus.lo_o, 32'h2222);
    check_eq("fl_ret", bus.retired, 32'd3);

    // Back-to-back MTHI 0x1 then 0x2.
    drive(5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h2222);
    tick();
    drive(5'd0, 1'b0, 32'h0, 1'b1, 32'h2, 32'h2222);
    #1;
    check_eq("b2b_hi_a", bus.hi_o, Byp ? 32'h2 : 32'h1111);
    tick();
    idle();
    #1;
    check_eq("b2b_hi_b", bus.hi_o, Byp ? 32'h2 : 32'h1);
    tick();
    check_eq("b2b_hi_c", bus.hi_o, 32'h2);
    check_eq("b2b_ret", bus.retired, 32'd5);

    // Counter wrap.
    drive(5'd6, 1'b1, 32'h66, 1'b0, 32'h0, 32'h0);
    tick();
    idle();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    check_eq("wrap_pre", bus.retired, 32'hFFFF_FFFF);
    tick();
    check_eq("wrap_zero", bus.retired, 32'h0);

    // GPR 0 writes pass through unchanged.
    drive(5'd0, 1'b1, 32'h77, 1'b0, 32'h0, 32'h0);
    tick();
    idle();
    check_eq("r0_wd", 32'(bus.wb_wd), 32'd0);
    check_eq("r0_wreg", 32'(bus.wb_wreg), 32'd1);
    check_eq("r0_wdata", bus.wb_wdata, 32'h77);
    tick();
    check_eq("r0_ret", bus.retired, 32'd1);

    // Reset during a held stall discards the bundle.
    drive(5'd8, 1'b1, 32'h88, 1'b0, 32'h0, 32'h0);
    tick();
    bus.stall_mem = 1'b1;
    bus.stall_wb  = 1'b1;
    rst = 1'b0;
    tick();
    rst           = 1'b1;
    bus.stall_mem = 1'b0;
    bus.stall_wb  = 1'b0;
    idle();
    #1;
    check_eq("rstst_wd", 32'(bus.wb_wd), 32'd0);
    check_eq("rstst_wreg", 32'(bus.wb_wreg), 32'd0);
    check_eq("rstst_ret", bus.retired, 32'd0);
    check_eq("rstst_hi", bus.hi_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
